// File: rtl/move_controller.sv
// Turn-based move sequencer for the 9x10 board: two-click select, ownership check,
// handshaked two-write commit, turn alternation and general-capture game over.
module move_controller #(
  parameter logic [2:0] GENERAL_TYPE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_valid,
  input  logic [7:0] sel_loc,
  input  logic       cancel,
  output logic       mem_req,
  output logic       mem_we,
  output logic [6:0] mem_addr,
  output logic [4:0] mem_wdata,
  input  logic [4:0] mem_rdata,
  input  logic       mem_ack,
  output logic       turn,
  output logic       src_held,
  output logic [7:0] src_loc,
  output logic       move_done,
  output logic       err,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    StIdle,
    StRdSrc,
    StWaitDst,
    StRdDst,
    StWrDst,
    StWrSrc,
    StDone,
    StOver
  } state_e;

  state_e     state_q, state_d;
  logic       turn_q, turn_d;
  logic       src_held_q, src_held_d;
  logic [7:0] src_loc_q, src_loc_d;
  logic [7:0] dst_loc_q, dst_loc_d;
  logic [4:0] piece_q, piece_d;
  logic       general_hit_q, general_hit_d;
  logic       move_done_q, move_done_d;
  logic       err_q, err_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_we_q, mem_we_d;
  logic [6:0] mem_addr_q, mem_addr_d;
  logic [4:0] mem_wdata_q, mem_wdata_d;

  logic own_piece;

  function automatic logic [6:0] loc_addr(input logic [7:0] loc);
    logic [6:0] col;
    logic [6:0] row;
    col = {3'b000, loc[7:4]};
    row = {3'b000, loc[3:0]};
    return (col << 3) + (col << 1) + row;
  endfunction

  function automatic logic in_range(input logic [7:0] loc);
    return (loc[7:4] <= 4'd8) && (loc[3:0] <= 4'd9);
  endfunction

  assign own_piece = mem_rdata[4] && (mem_rdata[3] == turn_q);

  always_comb begin
    state_d       = state_q;
    turn_d        = turn_q;
    src_held_d    = src_held_q;
    src_loc_d     = src_loc_q;
    dst_loc_d     = dst_loc_q;
    piece_d       = piece_q;
    general_hit_d = general_hit_q;
    move_done_d   = 1'b0;
    err_d         = 1'b0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          if (in_range(sel_loc)) begin
            src_loc_d = sel_loc;
            state_d   = StRdSrc;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StRdSrc: begin
        // Request goes out one cycle after entry; ack only counts while requesting.
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = loc_addr(src_loc_q);
          mem_wdata_d = 5'b00000;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (own_piece) begin
            piece_d    = mem_rdata;
            src_held_d = 1'b1;
            state_d    = StWaitDst;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StWaitDst: begin
        if (cancel) begin
          src_held_d = 1'b0;
          state_d    = StIdle;
        end else if (sel_valid) begin
          if (sel_loc == src_loc_q) begin
            src_held_d = 1'b0;
            state_d    = StIdle;
          end else if (!in_range(sel_loc)) begin
            err_d = 1'b1;
          end else begin
            dst_loc_d = sel_loc;
            state_d   = StRdDst;
          end
        end
      end

      StRdDst: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = loc_addr(dst_loc_q);
          mem_wdata_d = 5'b00000;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (own_piece) begin
            // Clicking another own piece moves the selection instead of capturing.
            src_loc_d = dst_loc_q;
            piece_d   = mem_rdata;
            state_d   = StWaitDst;
          end else begin
            general_hit_d = mem_rdata[4] && (mem_rdata[2:0] == GENERAL_TYPE);
            state_d       = StWrDst;
          end
        end
      end

      StWrDst: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = loc_addr(dst_loc_q);
          mem_wdata_d = piece_q;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StWrSrc;
        end
      end

      StWrSrc: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = loc_addr(src_loc_q);
          mem_wdata_d = 5'b00000;
        end else if (mem_ack) begin
          mem_req_d   = 1'b0;
          move_done_d = 1'b1;
          src_held_d  = 1'b0;
          state_d     = StDone;
        end
      end

      StDone: begin
        turn_d = ~turn_q;
        if (general_hit_q) begin
          game_over_d = 1'b1;
          winner_d    = turn_q;
          state_d     = StOver;
        end else begin
          state_d = StIdle;
        end
      end

      StOver: begin
        mem_req_d = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      turn_q        <= 1'b0;
      src_held_q    <= 1'b0;
      src_loc_q     <= 8'h00;
      dst_loc_q     <= 8'h00;
      piece_q       <= 5'b00000;
      general_hit_q <= 1'b0;
      move_done_q   <= 1'b0;
      err_q         <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 7'd0;
      mem_wdata_q   <= 5'b00000;
    end else begin
      state_q       <= state_d;
      turn_q        <= turn_d;
      src_held_q    <= src_held_d;
      src_loc_q     <= src_loc_d;
      dst_loc_q     <= dst_loc_d;
      piece_q       <= piece_d;
      general_hit_q <= general_hit_d;
      move_done_q   <= move_done_d;
      err_q         <= err_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign turn      = turn_q;
  assign src_held  = src_held_q;
  assign src_loc   = src_loc_q;
  assign move_done = move_done_q;
  assign err       = err_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: board memory model with programmable ack latency,
// expected write/err/move_done events queued by stimulus and matched by a monitor.
module tb_move_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_valid;
  logic [7:0] sel_loc;
  logic       cancel;
  logic       mem_req;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [4:0] mem_wdata;
  logic [4:0] mem_rdata;
  logic       mem_ack;
  logic       turn;
  logic       src_held;
  logic [7:0] src_loc;
  logic       move_done;
  logic       err;
  logic       game_over;
  logic       winner;

  always #5 clk = ~clk;

  move_controller #(.GENERAL_TYPE(3'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_valid (sel_valid),
    .sel_loc   (sel_loc),
    .cancel    (cancel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .turn      (turn),
    .src_held  (src_held),
    .src_loc   (src_loc),
    .move_done (move_done),
    .err       (err),
    .game_over (game_over),
    .winner    (winner)
  );

  localparam int EvWrite = 0;
  localparam int EvErr   = 1;
  localparam int EvDone  = 2;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;

  logic [4:0] board [0:127];
  int   ack_delay = 0;
  int   wait_cnt = 0;
  int   n_reads = 0;
  int   n_writes = 0;
  int   n_req_cycles = 0;
  logic       req_prev = 1'b0;
  logic       prev_we = 1'b0;
  logic [6:0] prev_addr = 7'd0;
  logic [4:0] prev_wdata = 5'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic expect_ev(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.a = a;
    e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic see_event(input int kind, input int a, input int b);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d expected none", kind, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b) begin
        bad++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d",
                 kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Memory model and output monitor, both on the falling edge.
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      n_req_cycles++;
      if (req_prev) begin
        check("bus_stable", {mem_we, mem_addr, mem_wdata}, {prev_we, prev_addr, prev_wdata});
      end
      if (wait_cnt == ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          board[mem_addr] = mem_wdata;
          n_writes++;
          see_event(EvWrite, int'(mem_addr), int'(mem_wdata));
        end else begin
          mem_rdata = board[mem_addr];
          n_reads++;
        end
      end else begin
        mem_ack = 1'b0;
      end
      wait_cnt++;
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
    req_prev   = (mem_req === 1'b1);
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    if (err === 1'b1) see_event(EvErr, 0, 0);
    if (move_done === 1'b1) see_event(EvDone, int'(turn), 0);
  end

  task automatic pick(input logic [7:0] loc);
    @(negedge clk);
    sel_valid = 1'b1;
    sel_loc = loc;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic wait_held();
    int n = 0;
    while (src_held !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_held_timeout", n < 100, 1);
  endtask

  task automatic move(input logic [7:0] src, input logic [7:0] dst);
    pick(src);
    wait_held();
    pick(dst);
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_q.size() != 0 || mem_req === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("settle_timeout", n < 300, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int r0;
    int q0;
    int n;
    for (int i = 0; i < 128; i++) board[i] = 5'b00000;
    board[0]  = 5'b10001;  // red chariot at 0x00
    board[20] = 5'b10010;  // red piece at 0x20
    board[13] = 5'b11010;  // black piece at 0x13
    board[49] = 5'b11000;  // black general at 0x49
    mem_ack = 1'b0;
    mem_rdata = 5'b00000;
    sel_valid = 1'b0;
    sel_loc = 8'h00;
    cancel = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_turn", turn, 0);
    check("rst_src_held", src_held, 0);
    check("rst_src_loc", src_loc, 0);
    check("rst_move_done", move_done, 0);
    check("rst_err", err, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;

    // Red move 0x00 -> 0x05, also checks source-select latency.
    pick(8'h00);
    @(negedge clk);
    check("src_lat_req", mem_req, 1);
    check("src_lat_held_early", src_held, 0);
    @(negedge clk);
    check("src_lat_held", src_held, 1);
    expect_ev(EvWrite, 5, 5'b10001);
    expect_ev(EvWrite, 0, 5'b00000);
    expect_ev(EvDone, 0, 0);
    pick(8'h05);
    settle();
    check("red_move_turn", turn, 1);
    check("red_move_dst", board[5], 5'b10001);
    check("red_move_src", board[0], 5'b00000);
    check("red_move_held", src_held, 0);

    // Black move 0x13 -> 0x14.
    expect_ev(EvWrite, 14, 5'b11010);
    expect_ev(EvWrite, 13, 5'b00000);
    expect_ev(EvDone, 1, 0);
    move(8'h13, 8'h14);
    settle();
    check("black_move_turn", turn, 0);

    // Wrong side: red to move, select black piece.
    w0 = n_writes;
    expect_ev(EvErr, 0, 0);
    pick(8'h14);
    settle();
    check("wrong_side_held", src_held, 0);
    check("wrong_side_writes", n_writes, w0);

    // Re-select and deselect.
    pick(8'h05);
    wait_held();
    pick(8'h20);
    repeat (6) @(negedge clk);
    check("reselect_loc", src_loc, 8'h20);
    check("reselect_held", src_held, 1);
    pick(8'h20);
    repeat (3) @(negedge clk);
    check("deselect_held", src_held, 0);
    check("deselect_writes", n_writes, w0);

    // Out-of-range selections in IDLE.
    expect_ev(EvErr, 0, 0);
    pick(8'h9A);
    settle();
    expect_ev(EvErr, 0, 0);
    pick(8'h0A);
    settle();

    // Out-of-range destination keeps the selection.
    pick(8'h05);
    wait_held();
    expect_ev(EvErr, 0, 0);
    pick(8'h9A);
    settle();
    check("dst_range_held", src_held, 1);

    // Cancel together with sel_valid: cancel wins, no destination read.
    r0 = n_reads;
    @(negedge clk);
    sel_valid = 1'b1;
    sel_loc = 8'h06;
    cancel = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
    cancel = 1'b0;
    repeat (5) @(negedge clk);
    check("cancel_held", src_held, 0);
    check("cancel_reads", n_reads, r0);

    // Stalled memory: red 0x05 -> 0x06 with 4-cycle ack delay.
    ack_delay = 4;
    expect_ev(EvWrite, 6, 5'b10001);
    expect_ev(EvWrite, 5, 5'b00000);
    expect_ev(EvDone, 0, 0);
    move(8'h05, 8'h06);
    settle();
    ack_delay = 0;
    check("stall_turn", turn, 1);
    check("stall_dst", board[6], 5'b10001);

    // Black 0x14 -> 0x15, then red captures the general at 0x49.
    expect_ev(EvWrite, 15, 5'b11010);
    expect_ev(EvWrite, 14, 5'b00000);
    expect_ev(EvDone, 1, 0);
    move(8'h14, 8'h15);
    settle();
    expect_ev(EvWrite, 49, 5'b10001);
    expect_ev(EvWrite, 6, 5'b00000);
    expect_ev(EvDone, 0, 0);
    move(8'h06, 8'h49);
    settle();
    check("capture_game_over", game_over, 1);
    check("capture_winner", winner, 0);
    check("capture_turn", turn, 1);
    q0 = n_req_cycles;
    pick(8'h15);
    pick(8'h16);
    repeat (10) @(negedge clk);
    check("over_no_req", n_req_cycles, q0);
    check("over_sticky", game_over, 1);

    // Reset while the source clear write is stalled.
    do_reset();
    @(negedge clk);
    check("reset_game_over", game_over, 0);
    check("reset_turn0", turn, 0);
    ack_delay = 4;
    expect_ev(EvWrite, 48, 5'b10001);
    move(8'h49, 8'h48);
    n = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1 && mem_addr == 7'd49) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wr_src_reach", n < 200, 1);
    check("wr_src_held", src_held, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_req", mem_req, 0);
    check("midreset_turn", turn, 0);
    check("midreset_held", src_held, 0);
    rst = 1'b1;
    ack_delay = 0;
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
